gat_bram_load_ctrl: RTL

//  Host-side sequencer for the GAT accelerator BRAM interface. Accepts one 32-bit word stream and writes
//  it, in fixed order, into the H-data, H-node-info, weight and subgraph-index BRAMs using byte addressing.

---
 rtl/gat_bram_load_ctrl_if.sv | 57 +++++
 rtl/gat_bram_load_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/gat_bram_load_ctrl_if.sv
// Stream, BRAM and readback signals shared by the GAT load controller and the host-side environment.
// The master modport is the controller; the slave modport is the stream source, BRAMs and sink.
interface gat_bram_load_ctrl_if #(
  parameter int TOP_WIDTH   = 32,
  parameter int BYTE_ADDR_W = 22
);
  logic                   s_valid;
  logic                   s_ready;
  logic [TOP_WIDTH-1:0]   s_data;

  logic [TOP_WIDTH-1:0]   h_data_bram_din;
  logic                   h_data_bram_ena;
  logic                   h_data_bram_wea;
  logic [BYTE_ADDR_W-1:0] h_data_bram_addra;

  logic [TOP_WIDTH-1:0]   h_node_info_bram_din;
  logic                   h_node_info_bram_ena;
  logic                   h_node_info_bram_wea;
  logic [BYTE_ADDR_W-1:0] h_node_info_bram_addra;

  logic [TOP_WIDTH-1:0]   wgt_bram_din;
  logic                   wgt_bram_ena;
  logic                   wgt_bram_wea;
  logic [BYTE_ADDR_W-1:0] wgt_bram_addra;

  logic [TOP_WIDTH-1:0]   subgraph_bram_din;
  logic                   subgraph_bram_ena;
  logic                   subgraph_bram_wea;
  logic [BYTE_ADDR_W-1:0] subgraph_bram_addra;

  logic [BYTE_ADDR_W-1:0] feat_bram_addrb;
  logic [TOP_WIDTH-1:0]   feat_bram_dout;

  logic                   m_valid;
  logic                   m_ready;
  logic [TOP_WIDTH-1:0]   m_data;

  modport master (
    input  s_valid, s_data, feat_bram_dout, m_ready,
    output s_ready,
    output h_data_bram_din, h_data_bram_ena, h_data_bram_wea, h_data_bram_addra,
    output h_node_info_bram_din, h_node_info_bram_ena, h_node_info_bram_wea, h_node_info_bram_addra,
    output wgt_bram_din, wgt_bram_ena, wgt_bram_wea, wgt_bram_addra,
    output subgraph_bram_din, subgraph_bram_ena, subgraph_bram_wea, subgraph_bram_addra,
    output feat_bram_addrb, m_valid, m_data
  );

  modport slave (
    output s_valid, s_data, feat_bram_dout, m_ready,
    input  s_ready,
    input  h_data_bram_din, h_data_bram_ena, h_data_bram_wea, h_data_bram_addra,
    input  h_node_info_bram_din, h_node_info_bram_ena, h_node_info_bram_wea, h_node_info_bram_addra,
    input  wgt_bram_din, wgt_bram_ena, wgt_bram_wea, wgt_bram_addra,
    input  subgraph_bram_din, subgraph_bram_ena, subgraph_bram_wea, subgraph_bram_addra,
    input  feat_bram_addrb, m_valid, m_data
  );
endinterface

// File: rtl/gat_bram_load_ctrl.sv
// Host-side sequencer: streams words into the four GAT input BRAMs in fixed order, waits for the
// accelerator, then reads the feature BRAM back one word at a time.
module gat_bram_load_ctrl #(
  parameter int TOP_WIDTH   = 32,
  parameter int BYTE_ADDR_W = 22,
  parameter int LEN_W       = 20,
  parameter int RD_LAT      = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [LEN_W-1:0] cfg_hdata_len_i,
  input  logic [LEN_W-1:0] cfg_ninfo_len_i,
  input  logic [LEN_W-1:0] cfg_wgt_len_i,
  input  logic [LEN_W-1:0] cfg_subg_len_i,
  input  logic [LEN_W-1:0] cfg_feat_len_i,
  input  logic             gat_ready_i,
  output logic             h_data_bram_load_done_o,
  output logic             h_node_info_bram_load_done_o,
  output logic             wgt_bram_load_done_o,
  output logic             busy_o,
  gat_bram_load_ctrl_if.master bus
);

  localparam int LAT_W = $clog2(RD_LAT + 1);

  typedef enum logic [3:0] {
    IDLE, L_HDATA, L_NINFO, L_WGT, L_SUBG, WAIT_GAT, RD_ISSUE, RD_WAIT, RD_OUT, DONE
  } state_t;

  state_t               state_q;
  logic [LEN_W-1:0]     idx_q, ridx_q;
  logic [LEN_W-1:0]     hdataLen_q, ninfoLen_q, wgtLen_q, subgLen_q, featLen_q;
  logic                 hdataDone_q, ninfoDone_q, wgtDone_q;
  logic                 mValid_q;
  logic [TOP_WIDTH-1:0] mData_q;
  logic [LAT_W-1:0]     latCnt_q;

  logic                   inLoad;
  logic [LEN_W-1:0]       curLen;
  logic                   sReady, fire, lastWord, regionEnd;
  logic                   selH, selN, selW, selS;
  logic [BYTE_ADDR_W-1:0] wrAddr;

  always_comb begin
    inLoad = 1'b0;
    curLen = '0;
    case (state_q)
      L_HDATA: begin inLoad = 1'b1; curLen = hdataLen_q; end
      L_NINFO: begin inLoad = 1'b1; curLen = ninfoLen_q; end
      L_WGT:   begin inLoad = 1'b1; curLen = wgtLen_q;   end
      L_SUBG:  begin inLoad = 1'b1; curLen = subgLen_q;  end
      default: ;
    endcase
  end

  // A zero-length region keeps s_ready low and simply falls through after one cycle.
  assign sReady    = inLoad && (curLen != '0);
  assign fire      = sReady && bus.s_valid;
  assign lastWord  = (idx_q == curLen - LEN_W'(1));
  assign regionEnd = inLoad && ((curLen == '0) || (fire && lastWord));
  assign wrAddr    = BYTE_ADDR_W'({idx_q, 2'b00});

  assign selH = fire && (state_q == L_HDATA);
  assign selN = fire && (state_q == L_NINFO);
  assign selW = fire && (state_q == L_WGT);
  assign selS = fire && (state_q == L_SUBG);

  assign bus.s_ready                = sReady;
  assign bus.h_data_bram_ena        = selH;
  assign bus.h_data_bram_wea        = selH;
  assign bus.h_data_bram_din        = selH ? bus.s_data : '0;
  assign bus.h_data_bram_addra      = selH ? wrAddr : '0;
  assign bus.h_node_info_bram_ena   = selN;
  assign bus.h_node_info_bram_wea   = selN;
  assign bus.h_node_info_bram_din   = selN ? bus.s_data : '0;
  assign bus.h_node_info_bram_addra = selN ? wrAddr : '0;
  assign bus.wgt_bram_ena           = selW;
  assign bus.wgt_bram_wea           = selW;
  assign bus.wgt_bram_din           = selW ? bus.s_data : '0;
  assign bus.wgt_bram_addra         = selW ? wrAddr : '0;
  assign bus.subgraph_bram_ena      = selS;
  assign bus.subgraph_bram_wea      = selS;
  assign bus.subgraph_bram_din      = selS ? bus.s_data : '0;
  assign bus.subgraph_bram_addra    = selS ? wrAddr : '0;

  // The read address follows ridx, so it is held through RD_WAIT and RD_OUT for free.
  assign bus.feat_bram_addrb = BYTE_ADDR_W'({ridx_q, 2'b00});
  assign bus.m_valid         = mValid_q;
  assign bus.m_data          = mData_q;

  assign h_data_bram_load_done_o      = hdataDone_q;
  assign h_node_info_bram_load_done_o = ninfoDone_q;
  assign wgt_bram_load_done_o         = wgtDone_q;
  assign busy_o                       = (state_q != IDLE) && (state_q != DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      ridx_q      <= '0;
      hdataLen_q  <= '0;
      ninfoLen_q  <= '0;
      wgtLen_q    <= '0;
      subgLen_q   <= '0;
      featLen_q   <= '0;
      hdataDone_q <= 1'b0;
      ninfoDone_q <= 1'b0;
      wgtDone_q   <= 1'b0;
      mValid_q    <= 1'b0;
      mData_q     <= '0;
      latCnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            hdataLen_q  <= cfg_hdata_len_i;
            ninfoLen_q  <= cfg_ninfo_len_i;
            wgtLen_q    <= cfg_wgt_len_i;
            subgLen_q   <= cfg_subg_len_i;
            featLen_q   <= cfg_feat_len_i;
            idx_q       <= '0;
            ridx_q      <= '0;
            hdataDone_q <= 1'b0;
            ninfoDone_q <= 1'b0;
            wgtDone_q   <= 1'b0;
            state_q     <= L_HDATA;
          end
        end
        L_HDATA, L_NINFO, L_WGT, L_SUBG: begin
          if (regionEnd) begin
            idx_q <= '0;
            case (state_q)
              L_HDATA: begin hdataDone_q <= 1'b1; state_q <= L_NINFO; end
              L_NINFO: begin ninfoDone_q <= 1'b1; state_q <= L_WGT;   end
              L_WGT:   begin wgtDone_q   <= 1'b1; state_q <= L_SUBG;  end
              default: state_q <= WAIT_GAT;
            endcase
          end else if (fire) begin
            idx_q <= idx_q + LEN_W'(1);
          end
        end
        WAIT_GAT: begin
          if (gat_ready_i) state_q <= (featLen_q == '0) ? DONE : RD_ISSUE;
        end
        RD_ISSUE: begin
          latCnt_q <= LAT_W'(1);
          state_q  <= RD_WAIT;
        end
        RD_WAIT: begin
          if (latCnt_q == LAT_W'(RD_LAT)) begin
            mData_q  <= bus.feat_bram_dout;
            mValid_q <= 1'b1;
            state_q  <= RD_OUT;
          end else begin
            latCnt_q <= latCnt_q + LAT_W'(1);
          end
        end
        RD_OUT: begin
          if (bus.m_ready) begin
            mValid_q <= 1'b0;
            ridx_q   <= ridx_q + LEN_W'(1);
            state_q  <= (ridx_q == featLen_q - LEN_W'(1)) ? DONE : RD_ISSUE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
